// File: rtl/uart_tx_sched.sv
// uart_tx_sched: two-port round-robin 8N1 UART transmitter; define UART_TX_PARITY_EN for an even parity bit
module uart_tx_sched #(
   parameter int unsigned BAUD_DIV = 5208
) (
   input  logic       clk_50m,
   input  logic       rst_n,
   input  logic       req0,
   input  logic [7:0] data0,
   output logic       gnt0,
   input  logic       req1,
   input  logic [7:0] data1,
   output logic       gnt1,
   output logic       txd,
   output logic       busy,
   output logic       done,
   output logic       last_src
);
`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   logic par;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
   localparam logic [15:0] RELOAD = 16'(BAUD_DIV - 1);
   state_t      state;
   logic [15:0] baud;
   logic [7:0]  shift;
   logic [2:0]  idx;
   logic        bit_end;
   logic        pick1;
   logic [7:0]  sel_data;
   assign bit_end = baud == 16'd0;
   // port 1 wins when it is alone or when port 0 was served last
   assign pick1 = req1 && (!req0 || !last_src);
   assign sel_data = pick1 ? data1 : data0;
   always_ff @(posedge clk_50m or negedge rst_n)
      if (!rst_n) begin
         state    <= IDLE;
         baud     <= '0;
         shift    <= '0;
         idx      <= '0;
         txd      <= 1'b1;
         busy     <= 1'b0;
         gnt0     <= 1'b0;
         gnt1     <= 1'b0;
         done     <= 1'b0;
         last_src <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par      <= 1'b0;
`endif
      end else begin
         gnt0 <= 1'b0;
         gnt1 <= 1'b0;
         done <= state == STOP && baud == 16'd1;
         if (state != IDLE)
            baud <= bit_end ? RELOAD : baud - 16'd1;
         case (state)
            IDLE:
               if (req0 || req1) begin
                  gnt0     <= !pick1;
                  gnt1     <= pick1;
                  shift    <= sel_data;
                  last_src <= pick1;
                  busy     <= 1'b1;
                  txd      <= 1'b0;
                  baud     <= RELOAD;
                  state    <= START;
`ifdef UART_TX_PARITY_EN
                  par      <= ^sel_data;
`endif
               end
            START:
               if (bit_end) begin
                  txd   <= shift[0];
                  idx   <= '0;
                  state <= DATA;
               end
            DATA:
               if (bit_end) begin
                  if (idx != 3'd7) begin
                     shift <= shift >> 1;
                     txd   <= shift[1];
                     idx   <= idx + 3'd1;
                  end else begin
`ifdef UART_TX_PARITY_EN
                     txd   <= par;
                     state <= PARITY;
`else
                     txd   <= 1'b1;
                     state <= STOP;
`endif
                  end
               end
`ifdef UART_TX_PARITY_EN
            PARITY:
               if (bit_end) begin
                  txd   <= 1'b1;
                  state <= STOP;
               end
`endif
            STOP:
               if (bit_end) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: vector table, hand sequences and random arbitration against a frame-level reference model
module tb_uart_tx_sched;
   localparam int BD = 4;
   localparam int BD2 = 5208;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   typedef struct {
      logic       r0;
      logic       r1;
      logic [7:0] d0;
      logic [7:0] d1;
      int         src;
      logic [7:0] b;
   } vec_t;
   logic       clk_50m = 1'b0;
   logic       rst_n = 1'b0;
   logic       req0 = 1'b0, req1 = 1'b0;
   logic [7:0] data0 = 8'h00, data1 = 8'h00;
   logic       gnt0, gnt1, txd, busy, done, last_src;
   logic       req0b = 1'b0;
   logic [7:0] data0b = 8'h00;
   logic       gnt0b, gnt1b, txdb, busyb, doneb, last_srcb;
   int         checks = 0;
   int         errors = 0;
   vec_t       tbl [11];
   always #5 clk_50m = ~clk_50m;
   uart_tx_sched #(.BAUD_DIV(BD)) dut (
      .clk_50m(clk_50m), .rst_n(rst_n),
      .req0(req0), .data0(data0), .gnt0(gnt0),
      .req1(req1), .data1(data1), .gnt1(gnt1),
      .txd(txd), .busy(busy), .done(done), .last_src(last_src)
   );
   uart_tx_sched dut2 (
      .clk_50m(clk_50m), .rst_n(rst_n),
      .req0(req0b), .data0(data0b), .gnt0(gnt0b),
      .req1(1'b0), .data1(8'h00), .gnt1(gnt1b),
      .txd(txdb), .busy(busyb), .done(doneb), .last_src(last_srcb)
   );
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   // line level of a frame in bit slot s: start, 8 data LSB first, optional parity, stop
   function automatic logic frame_bit(input logic [7:0] b, input int s);
      if (s == 0) return 1'b0;
      if (s <= 8) return b[s-1];
`ifdef UART_TX_PARITY_EN
      if (s == 9) return ^b;
`endif
      return 1'b1;
   endfunction
   // act: 0 keep requests, 1 drop both, 2 bump granted data, 4 drop granted request
   task automatic frame(input int exp_src, input logic [7:0] exp_byte, input int act);
      int n, bad_i, bad_t, bad_b, bad_d, bad_g;
      logic [7:0] rx;
      n = 0; bad_i = 0; bad_t = 0; bad_b = 0; bad_d = 0; bad_g = 0; rx = 8'h00;
      while (!(gnt0 || gnt1) && n < 50) begin
         if (txd !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad_i++;
         @(negedge clk_50m);
         n++;
      end
      chk("idle_outputs", bad_i, 0);
      chk("grant_gap", n, 1);
      if (n >= 50) return;
      chk("grant_port", {gnt1, gnt0}, exp_src ? 2 : 1);
      chk("last_src", last_src, exp_src);
      if (act == 1) begin req0 = 1'b0; req1 = 1'b0; end
      if (act == 2) begin if (exp_src == 1) data1 = data1 + 8'd1; else data0 = data0 + 8'd1; end
      if (act == 4) begin if (exp_src == 1) req1 = 1'b0; else req0 = 1'b0; end
      for (int k = 0; k < NB * BD; k++) begin
         if (txd !== frame_bit(exp_byte, k / BD)) bad_t++;
         if (k / BD >= 1 && k / BD <= 8 && k % BD == BD / 2) rx[k / BD - 1] = txd;
         if (busy !== 1'b1) bad_b++;
         if (done !== (k == NB * BD - 1)) bad_d++;
         if (k > 0 && (gnt0 || gnt1)) bad_g++;
         @(negedge clk_50m);
      end
      chk("rx_byte", rx, exp_byte);
      chk("txd_timing_errs", bad_t, 0);
      chk("busy_errs", bad_b, 0);
      chk("done_errs", bad_d, 0);
      chk("extra_grants", bad_g, 0);
   endtask
   initial begin
      int n, bad, src, ml, bt, bb, bd;
      tbl[0]  = '{1'b1, 1'b0, 8'hA5, 8'h00, 0, 8'hA5};
      tbl[1]  = '{1'b1, 1'b1, 8'h3C, 8'hC3, 1, 8'hC3};
      tbl[2]  = '{1'b1, 1'b1, 8'h5A, 8'h96, 0, 8'h5A};
      tbl[3]  = '{1'b0, 1'b1, 8'h00, 8'hFF, 1, 8'hFF};
      tbl[4]  = '{1'b0, 1'b1, 8'h00, 8'h00, 1, 8'h00};
      tbl[5]  = '{1'b1, 1'b1, 8'h81, 8'h7E, 0, 8'h81};
      tbl[6]  = '{1'b1, 1'b0, 8'h07, 8'h00, 0, 8'h07};
      tbl[7]  = '{1'b1, 1'b0, 8'h03, 8'h00, 0, 8'h03};
      tbl[8]  = '{1'b1, 1'b1, 8'h12, 8'h34, 1, 8'h34};
      tbl[9]  = '{1'b1, 1'b1, 8'h66, 8'h99, 0, 8'h66};
      tbl[10] = '{1'b0, 1'b1, 8'h00, 8'h80, 1, 8'h80};
      repeat (3) @(negedge clk_50m);
      chk("rst_txd", txd, 1);
      chk("rst_busy", busy, 0);
      chk("rst_gnt", {gnt1, gnt0}, 0);
      chk("rst_done", done, 0);
      chk("rst_last_src", last_src, 1);
      chk("rst_txd_dut2", txdb, 1);
      rst_n = 1'b1;
      foreach (tbl[i]) begin
         req0 = tbl[i].r0; data0 = tbl[i].d0;
         req1 = tbl[i].r1; data1 = tbl[i].d1;
         frame(tbl[i].src, tbl[i].b, 1);
      end
      req0 = 1'b1; data0 = 8'h11; req1 = 1'b1; data1 = 8'h22;
      frame(0, 8'h11, 0);
      frame(1, 8'h22, 0);
      frame(0, 8'h11, 0);
      frame(1, 8'h22, 1);
      req1 = 1'b1; data1 = 8'h00;
      frame(1, 8'h00, 2);
      frame(1, 8'h01, 2);
      frame(1, 8'h02, 1);
      req0 = 1'b1; data0 = 8'hC6; n = 0;
      while (!gnt0 && n < 50) begin @(negedge clk_50m); n++; end
      chk("abort_grant", gnt0, 1);
      req1 = 1'b1; data1 = 8'h5D;
      repeat (4 * BD + 1) @(negedge clk_50m);
      chk("abort_pre_busy", busy, 1);
      chk("abort_pre_txd", txd, 0);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_txd", txd, 1);
      chk("abort_busy", busy, 0);
      bad = 0;
      repeat (3) begin
         @(negedge clk_50m);
         if (done || gnt0 || gnt1 || txd !== 1'b1) bad++;
      end
      chk("abort_quiet", bad, 0);
      rst_n = 1'b1;
      frame(0, 8'hC6, 4);
      frame(1, 8'h5D, 1);
      ml = 1;
      for (int i = 0; i < 30; i++) begin
         if (!req0 && $urandom_range(0, 1) == 1) begin req0 = 1'b1; data0 = 8'($urandom); end
         if (!req1 && $urandom_range(0, 1) == 1) begin req1 = 1'b1; data1 = 8'($urandom); end
         if (!req0 && !req1) begin req0 = 1'b1; data0 = 8'($urandom); end
         src = (req0 && req1) ? 1 - ml : (req1 ? 1 : 0);
         frame(src, src == 1 ? data1 : data0, 4);
         ml = src;
      end
      req0 = 1'b0; req1 = 1'b0;
      req0b = 1'b1; data0b = 8'h55; n = 0;
      while (!gnt0b && n < 50) begin @(negedge clk_50m); n++; end
      chk("d2_grant", gnt0b, 1);
      req0b = 1'b0;
      bt = 0; bb = 0; bd = 0;
      for (int k = 0; k < NB * BD2; k++) begin
         if (txdb !== frame_bit(8'h55, k / BD2)) bt++;
         if (busyb !== 1'b1) bb++;
         if (doneb !== (k == NB * BD2 - 1)) bd++;
         @(negedge clk_50m);
      end
      chk("d2_txd_timing_errs", bt, 0);
      chk("d2_busy_errs", bb, 0);
      chk("d2_done_errs", bd, 0);
      chk("d2_busy_fall", busyb, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Shares a single 8N1 UART transmitter between two byte requesters: port 0 (image-transfer ack/status) and port 1 (debug/diagnostic).
- Round-robin arbitration, byte serialization and bit timing all run in the clk_50m domain.
- Bit timing uses an internal baud counter acting as a clock enable; no derived clocks.
- Sits between the frame-control logic and the board TXD pin.

Parameters:
- BAUD_DIV, 5208, clk_50m cycles per UART bit (50 MHz / 9600); legal range 2..65535.

Ports:
- clk_50m  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- req0  in  1  requester 0 has a byte pending; hold high until gnt0
- data0  in  8  requester 0 byte; stable while req0 high
- gnt0  out  1  one-cycle pulse: data0 latched, requester 0 may change data/drop req
- req1  in  1  requester 1 pending
- data1  in  8  requester 1 byte
- gnt1  out  1  one-cycle grant pulse for requester 1
- txd  out  1  serial output, idle high
- busy  out  1  high from grant cycle through end of stop bit
- done  out  1  one-cycle pulse on last cycle of stop bit
- last_src  out  1  source of most recently granted byte (0/1)

Behaviour:
- Reset (async assert, sync release): txd=1, busy=0, gnt0=gnt1=0, done=0, last_src=1 (so port 0 wins first), FSM=IDLE, baud counter=0, shift reg=0.
- FSM states: IDLE, START, DATA, [PARITY], STOP.
- IDLE: if any req is high, grant on the next clk_50m edge.
  - Only one requesting: grant it.
  - Both requesting: grant the port != last_src.
  - On the grant edge: gntN=1 for exactly one cycle, shift<=dataN, last_src<=N, busy<=1, txd<=0, baud counter<=BAUD_DIV-1, state<=START.
- Baud counter: decrements each cycle; a "bit end" occurs when it equals 0, at which point it reloads BAUD_DIV-1. Every bit lasts exactly BAUD_DIV cycles.
- START bit end: txd<=shift[0], bit index<=0, state<=DATA.
- DATA bit end:
  - If index<7: shift right, txd<=next LSB, index+1.
  - If index==7: txd<=1, state<=STOP.
  - LSB first.
- STOP bit end: done=1 for that cycle, busy<=0, state<=IDLE, txd stays 1.
- Frame length: 10*BAUD_DIV cycles from the grant edge to the busy fall.
- Minimum gap: 1 idle cycle (txd=1) between back-to-back frames. A req present in IDLE is granted on the next edge.
- req edges during busy are ignored, but a req held high is kept pending. Requests are never lost and never double-granted; a gnt is issued only in IDLE.
- A requester that drops req before its grant gets no grant; its byte is not sent.
- Reset mid-frame: immediate abort, txd=1; no done pulse; no gnt for the aborted byte.
- done and gnt never assert in the same cycle.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined:
  - PARITY state inserted after DATA; txd=even parity (XOR of the 8 data bits) for BAUD_DIV cycles, then STOP.
  - Frame length is 11*BAUD_DIV cycles.
- Undefined:
  - No PARITY state or parity logic; 8N1 as above.

Test Plan:
- BAUD_DIV=4, single byte: req0=1, data0=8'hA5 -> gnt0 pulses once. txd reads 0 (start), then 1,0,1,0,0,1,0,1, then 1 (stop), each bit 4 cycles. done pulses at cycle 39 after grant; busy high for 40 cycles.
- Simultaneous requests: req0=req1=1 held, data0=8'h11, data1=8'h22 -> order 11, 22, 11, 22. Grants alternate, last_src toggles, exactly 1 idle cycle between frames.
- Single requester streaming: req1 held, data1 increments on each gnt1 from 8'h00 -> bytes 00, 01, 02 sent consecutively with no arbitration stall by the idle port 0.
- Reset mid-frame: assert rst_n=0 at data bit 3 -> txd=1 and busy=0 immediately, no done. After release with req0=1, a fresh frame starts from the start bit.
- Default BAUD_DIV=5208, byte 8'h55 -> each bit 5208 cycles (104.16 us), frame 52080 cycles.
- With UART_TX_PARITY_EN, byte 8'h07 -> parity bit=1, frame 44 cycles at BAUD_DIV=4. With byte 8'h03 -> parity bit=0.
